button_tick_conditioner: RTL and testbench

BUTTON_TICK_CONDITIONER -- requirements
Module: button_tick_conditioner

---
 rtl/timer_pkg.sv | 18 +
 rtl/button_tick_conditioner_if.sv | 31 +++
 rtl/button_tick_conditioner_debouncer.sv | 54 +++++
 rtl/button_tick_conditioner.sv | 92 +++++++++
 tb/tb_button_tick_conditioner.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the stopwatch front end.
//   DEFAULT_CLK_FREQ_HZ : default system clock frequency
//   TICK_RATE_HZ        : timer core time-base rate (centiseconds)
//   MS_PER_TICK         : milliseconds per timer-core tick
//   BTN_*_IDX           : bit positions inside buttonLevel
package timer_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 100_000_000;
  localparam int unsigned TICK_RATE_HZ        = 100;
  localparam int unsigned MS_PER_TICK         = 1000 / TICK_RATE_HZ;

  localparam int unsigned BTN_SPLIT_IDX = 2;
  localparam int unsigned BTN_MODE_IDX  = 1;
  localparam int unsigned BTN_START_IDX = 0;

  typedef logic [2:0] btn_vec_t;

endpackage

// File: rtl/button_tick_conditioner_if.sv
// button_tick_conditioner_if: raw button levels in, conditioned pulses,
// time-base ticks and debounced levels out.
//   master : the side that owns the buttons and consumes the pulses
//   slave  : the conditioner itself
interface button_tick_conditioner_if;
  import timer_pkg::*;

  logic     rawSplitOrReset;
  logic     rawModeInput;
  logic     rawStartOrStop;
  logic     splitOrResetPulse;
  logic     modeInputPulse;
  logic     startOrStopPulse;
  logic     longPressPulse;
  logic     msTick;
  logic     tick100Hz;
  btn_vec_t buttonLevel;

  modport master (
    output rawSplitOrReset, rawModeInput, rawStartOrStop,
    input  splitOrResetPulse, modeInputPulse, startOrStopPulse,
    input  longPressPulse, msTick, tick100Hz, buttonLevel
  );

  modport slave (
    input  rawSplitOrReset, rawModeInput, rawStartOrStop,
    output splitOrResetPulse, modeInputPulse, startOrStopPulse,
    output longPressPulse, msTick, tick100Hz, buttonLevel
  );

endinterface

// File: rtl/button_tick_conditioner_debouncer.sv
// button_debouncer: two-flop synchronizer, millisecond debounce and a
// registered one-cycle press pulse for a single push button.
//   clk, rst : system clock, synchronous active-high reset
//   ms_tick  : one-cycle 1 ms strobe
//   raw      : asynchronous button level, 1 = pressed
//   level    : debounced level
//   pulse    : one cycle high the cycle after level rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync_a;
  logic       sync_b;
  logic       level_q;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      pulse   <= level & ~level_q;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (ms_tick) begin
        // The increment that would make cnt equal DEBOUNCE_MS accepts the
        // new level and clears the counter in one step.
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/button_tick_conditioner.sv
// button_tick_conditioner: stopwatch button front end and time base.
//   clockSignal : system clock, rising edge
//   resetSignal : synchronous active-high reset
//   btn         : raw button levels in; press pulses, long-press pulse,
//                 1 ms tick, 100 Hz tick and debounced levels out
module button_tick_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input logic                       clockSignal,
  input logic                       resetSignal,
  button_tick_conditioner_if.slave  btn
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned PW         = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CYC_PER_MS - 1);
  localparam logic [3:0]    DEC_MAX  = 4'(MS_PER_TICK - 1);
  localparam logic [15:0]   HOLD_MAX = 16'(LONG_PRESS_MS);

  logic [PW-1:0] pre_cnt;
  logic [3:0]    dec_cnt;
  logic [15:0]   hold_cnt;
  logic          ms_tick;
  logic          at_max;
  logic          at_max_q;
  logic          long_pulse;
  btn_vec_t      level;
  btn_vec_t      pulse;

  // Gated so a 1-cycle prescaler (1 kHz clock) still reads 0 during reset.
  assign ms_tick = ~resetSignal & (pre_cnt == PRE_MAX);
  assign at_max  = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      pre_cnt <= '0;
      dec_cnt <= '0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
      if (ms_tick) begin
        dec_cnt <= (dec_cnt == DEC_MAX) ? '0 : dec_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clockSignal) begin
    if (resetSignal) begin
      hold_cnt   <= '0;
      at_max_q   <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      if (!level[BTN_SPLIT_IDX]) begin
        hold_cnt <= '0;
      end else if (ms_tick && !at_max) begin
        hold_cnt <= hold_cnt + 16'd1;
      end
      at_max_q   <= at_max;
      long_pulse <= at_max & ~at_max_q;
    end
  end

  button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_split (
    .clk(clockSignal), .rst(resetSignal), .ms_tick(ms_tick),
    .raw(btn.rawSplitOrReset),
    .level(level[BTN_SPLIT_IDX]), .pulse(pulse[BTN_SPLIT_IDX])
  );

  button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
    .clk(clockSignal), .rst(resetSignal), .ms_tick(ms_tick),
    .raw(btn.rawModeInput),
    .level(level[BTN_MODE_IDX]), .pulse(pulse[BTN_MODE_IDX])
  );

  button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start (
    .clk(clockSignal), .rst(resetSignal), .ms_tick(ms_tick),
    .raw(btn.rawStartOrStop),
    .level(level[BTN_START_IDX]), .pulse(pulse[BTN_START_IDX])
  );

  assign btn.splitOrResetPulse = pulse[BTN_SPLIT_IDX];
  assign btn.modeInputPulse    = pulse[BTN_MODE_IDX];
  assign btn.startOrStopPulse  = pulse[BTN_START_IDX];
  assign btn.longPressPulse    = long_pulse;
  assign btn.msTick            = ms_tick;
  assign btn.tick100Hz         = ms_tick & (dec_cnt == DEC_MAX);
  assign btn.buttonLevel       = level;

endmodule

// File: tb/tb_button_tick_conditioner.sv
module tb_button_tick_conditioner;

  typedef struct {
    logic [2:0] mask;       // {split, mode, start} held high
    int         hold;       // cycles held before release
    int         exp_pulses; // press pulses per held button
    int         exp_long;   // long-press pulses
    int         lat_min;
    int         lat_max;
  } press_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_tick_conditioner_if bus ();

  button_tick_conditioner #(
    .CLK_FREQ_HZ(10_000),
    .DEBOUNCE_MS(3),
    .LONG_PRESS_MS(10)
  ) dut (
    .clockSignal(clk),
    .resetSignal(rst),
    .btn(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int pcnt[3];
  int pfirst[3];
  int lcnt;
  int lfirst;
  logic [2:0] level_or;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.splitOrResetPulse, bus.modeInputPulse, bus.startOrStopPulse,
            bus.longPressPulse, bus.msTick, bus.tick100Hz, bus.buttonLevel};
  endfunction

  task automatic set_raw(input logic [2:0] m);
    bus.rawSplitOrReset = m[2];
    bus.rawModeInput    = m[1];
    bus.rawStartOrStop  = m[0];
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      pcnt[i]   = 0;
      pfirst[i] = -1;
    end
    lcnt     = 0;
    lfirst   = -1;
    level_or = 3'b000;
    t0       = cyc;
  endtask

  task automatic step();
    logic [2:0] pv;
    @(posedge clk);
    #1;
    cyc++;
    pv = {bus.splitOrResetPulse, bus.modeInputPulse, bus.startOrStopPulse};
    for (int i = 0; i < 3; i++) begin
      if (pv[i]) begin
        pcnt[i]++;
        if (pfirst[i] < 0) pfirst[i] = cyc - t0;
      end
    end
    if (bus.longPressPulse) begin
      lcnt++;
      if (lfirst < 0) lfirst = cyc - t0;
    end
    level_or |= bus.buttonLevel;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  press_vec_t vecs[5];

  initial begin
    // mask, hold, pulses, long, latency window
    vecs[0] = '{3'b001, 200, 1, 0, 23, 33};
    vecs[1] = '{3'b001,  15, 0, 0,  0,  0};
    vecs[2] = '{3'b010, 200, 1, 0, 23, 33};
    vecs[3] = '{3'b111, 150, 1, 1, 23, 33};
    vecs[4] = '{3'b100,  60, 1, 0, 23, 33};

    set_raw(3'b000);
    clear_stats();

    // Reset state
    rst = 1'b1;
    steps(5);
    check("reset_outs", int'(outs()), 0);

    // Idle time base after release: msTick after edges 9,19,..; tick100Hz after 99,199
    rst = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      step();
      check("idle_ms",    int'(bus.msTick),    int'(k % 10 == 9));
      check("idle_100hz", int'(bus.tick100Hz), int'(k % 100 == 99));
    end
    check("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + lcnt, 0);
    check("idle_level", int'(level_or), 0);

    // Table-driven press scenarios
    for (int v = 0; v < 5; v++) begin
      clear_stats();
      set_raw(vecs[v].mask);
      steps(vecs[v].hold);
      set_raw(3'b000);
      steps(80);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("vec%0d_pulses_b%0d", v, i), pcnt[i],
              vecs[v].mask[i] ? vecs[v].exp_pulses : 0);
        if (vecs[v].mask[i] && vecs[v].exp_pulses > 0)
          check_range($sformatf("vec%0d_latency_b%0d", v, i), pfirst[i],
                      vecs[v].lat_min, vecs[v].lat_max);
      end
      check($sformatf("vec%0d_long", v), lcnt, vecs[v].exp_long);
      check($sformatf("vec%0d_level_seen", v), int'(level_or),
            vecs[v].exp_pulses > 0 ? int'(vecs[v].mask) : 0);
      if (vecs[v].mask == 3'b111) begin
        check("simul_mode_vs_start", pfirst[1], pfirst[0]);
        check("simul_split_vs_start", pfirst[2], pfirst[0]);
      end
      check($sformatf("vec%0d_level_end", v), int'(bus.buttonLevel), 0);
    end

    // Bounce on mode: 5-cycle toggles for 30 cycles, then held
    clear_stats();
    for (int s = 0; s < 6; s++) begin
      set_raw((s % 2 == 0) ? 3'b010 : 3'b000);
      steps(5);
    end
    check("bounce_no_early_pulse", pcnt[1], 0);
    check("bounce_no_early_level", int'(level_or), 0);
    set_raw(3'b010);
    t0 = cyc;
    steps(60);
    check("bounce_pulses", pcnt[1], 1);
    check_range("bounce_latency", pfirst[1], 23, 33);
    set_raw(3'b000);
    steps(80);
    check("bounce_no_release_pulse", pcnt[1], 1);

    // Long press on split, twice
    for (int r = 0; r < 2; r++) begin
      clear_stats();
      set_raw(3'b100);
      steps(300);
      check($sformatf("long%0d_split_pulses", r), pcnt[2], 1);
      check_range($sformatf("long%0d_split_latency", r), pfirst[2], 23, 33);
      check($sformatf("long%0d_long_pulses", r), lcnt, 1);
      check($sformatf("long%0d_long_delay", r), lfirst - pfirst[2], 100);
      check($sformatf("long%0d_level", r), int'(bus.buttonLevel), 4);
      set_raw(3'b000);
      steps(80);
      check($sformatf("long%0d_release", r), pcnt[2] + lcnt, 2);
    end

    // Reset mid-hold with mode held
    clear_stats();
    set_raw(3'b010);
    steps(60);
    check("rst_hold_pre_pulse", pcnt[1], 1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst_hold_outs%0d", i), int'(outs()), 0);
    end
    rst = 1'b0;
    clear_stats();
    steps(30);
    check("rst_hold_level_at30", int'(bus.buttonLevel), 2);
    check("rst_hold_no_pulse_yet", pcnt[1], 0);
    steps(50);
    check("rst_hold_pulses", pcnt[1], 1);
    check("rst_hold_pulse_at", pfirst[1], 31);
    set_raw(3'b000);
    steps(80);
    check("rst_hold_release", pcnt[1], 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
